regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RISC-V core; successor to the 2R/1W RegFile.

---
 rtl/regfile_mp.sv | 93 +++++++++
 tb/tb_regfile_mp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard for issue/writeback.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*XLEN-1:0]  rd,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr
);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0][XLEN-1:0] wdat;
    logic [NREG-1:0]           wen;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           iss_set;
    logic [AW-1:0]             waddr;
    logic [AW-1:0]             raddr;

    // Per-register write resolution; ascending port order lets the highest index win.
    always_comb begin
        wen   = '0;
        wdat  = '0;
        waddr = '0;
        for (int unsigned k = 0; k < NWR; k++) begin
            waddr = wa[k*AW +: AW];
            if (we[k] && waddr != '0) begin
                wen[waddr]  = 1'b1;
                wdat[waddr] = wd[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        iss_set = '0;
        if (iss_valid && iss_addr != '0)
            iss_set[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++)
                if (wen[r])
                    regs[r] <= wdat[r];
        end
    end

    // Issue sets busy, writeback clears it; a simultaneous issue takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (iss_set[r])
                    busy[r] <= 1'b1;
                else if (wen[r])
                    busy[r] <= 1'b0;
            end
        end
    end

    // Outputs are gated by rst_n so a bypassed write cannot leak through during reset.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        raddr   = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            raddr = ra[j*AW +: AW];
            if (rst_n && raddr != '0) begin
                rd[j*XLEN +: XLEN] = regs[raddr];
                rd_busy[j]         = busy[raddr];
                if (BYPASS != 0 && wen[raddr]) begin
                    rd[j*XLEN +: XLEN] = wdat[raddr];
                    rd_busy[j]         = busy[raddr] & iss_set[raddr];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and model-based checks of regfile_mp; two instances share stimulus,
// one with bypass enabled and one without.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [63:0] rd_b, rd_n;
    logic [1:0]  bz_b, bz_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    logic        mbusy [32];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_b), .rd_busy(bz_b), .iss_valid(iss_valid), .iss_addr(iss_addr)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_n), .rd_busy(bz_n), .iss_valid(iss_valid), .iss_addr(iss_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic test_reset();
        logic [4:0] a0, a1;
        rst_n = 1'b0;
        idle();
        ra = {5'd2, 5'd1};
        #1;
        checks++; if (rd_b !== 64'h0 || rd_n !== 64'h0) begin errors++; $display("FAIL reset_init_rd got %h/%h exp 0", rd_b, rd_n); end
        checks++; if (bz_b !== 2'b00 || bz_n !== 2'b00) begin errors++; $display("FAIL reset_init_busy got %b/%b exp 00", bz_b, bz_n); end
        tick();
        rst_n = 1'b1;
        we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'h22, 32'h11}; iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        ra = {5'd3, 5'd1};
        #1;
        checks++; if (rd_b !== {32'h0, 32'h11}) begin errors++; $display("FAIL reset_prewrite_rd got %h exp %h", rd_b, {32'h0, 32'h11}); end
        checks++; if (bz_b !== 2'b10) begin errors++; $display("FAIL reset_prewrite_busy got %b exp 10", bz_b); end
        we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'hDEAD, 32'hBEEF}; iss_valid = 1'b1; iss_addr = 5'd4;
        ra = {5'd2, 5'd1};
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_b !== 64'h0 || rd_n !== 64'h0) begin errors++; $display("FAIL reset_async_rd got %h/%h exp 0", rd_b, rd_n); end
        checks++; if (bz_b !== 2'b00 || bz_n !== 2'b00) begin errors++; $display("FAIL reset_async_busy got %b/%b exp 00", bz_b, bz_n); end
        tick();
        idle();
        rst_n = 1'b1;
        for (int r = 1; r < 32; r++) begin
            a0 = 5'(r);
            a1 = 5'(32 - r);
            ra = {a1, a0};
            #1;
            checks++;
            if (rd_b !== 64'h0 || rd_n !== 64'h0 || bz_b !== 2'b00 || bz_n !== 2'b00) begin
                errors++;
                $display("FAIL reset_post_x%0d got %h/%h busy %b/%b exp 0", r, rd_b, rd_n, bz_b, bz_n);
            end
        end
    endtask

    task automatic test_basic();
        we = 2'b01; wa = {5'd0, 5'd1}; wd = {32'h0, 32'd1};
        tick();
        wa = {5'd0, 5'd2}; wd = {32'h0, 32'd2};
        tick();
        wa = {5'd0, 5'd3}; wd = {32'h0, 32'd3};
        tick();
        idle();
        ra = {5'd3, 5'd2};
        #1;
        checks++; if (rd_b !== {32'd3, 32'd2}) begin errors++; $display("FAIL basic_23_byp got %h exp %h", rd_b, {32'd3, 32'd2}); end
        checks++; if (rd_n !== {32'd3, 32'd2}) begin errors++; $display("FAIL basic_23_nobyp got %h exp %h", rd_n, {32'd3, 32'd2}); end
        ra = {5'd1, 5'd0};
        #1;
        checks++; if (rd_b !== {32'd1, 32'd0}) begin errors++; $display("FAIL basic_01_byp got %h exp %h", rd_b, {32'd1, 32'd0}); end
        checks++; if (rd_n !== {32'd1, 32'd0}) begin errors++; $display("FAIL basic_01_nobyp got %h exp %h", rd_n, {32'd1, 32'd0}); end
    endtask

    task automatic test_x0_conflict();
        we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'hBB, 32'hAA}; ra = {5'd0, 5'd5};
        #1;
        checks++; if (rd_b !== {32'h0, 32'hBB}) begin errors++; $display("FAIL conflict_bypass got %h exp %h", rd_b, {32'h0, 32'hBB}); end
        checks++; if (rd_n !== 64'h0) begin errors++; $display("FAIL conflict_prior got %h exp 0", rd_n); end
        tick();
        idle();
        #1;
        checks++; if (rd_b !== {32'h0, 32'hBB} || rd_n !== {32'h0, 32'hBB}) begin errors++; $display("FAIL conflict_commit got %h/%h exp %h", rd_b, rd_n, {32'h0, 32'hBB}); end
        we = 2'b01; wa = {5'd6, 5'd6}; wd = {32'h22, 32'h11};
        tick();
        idle();
        ra = {5'd6, 5'd6};
        #1;
        checks++; if (rd_n !== {32'h11, 32'h11}) begin errors++; $display("FAIL masked_port got %h exp %h", rd_n, {32'h11, 32'h11}); end
        we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'h1234, 32'hFFFF}; ra = {5'd0, 5'd0};
        #1;
        checks++; if (rd_b !== 64'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rd_b); end
        tick();
        idle();
        #1;
        checks++; if (rd_b !== 64'h0 || rd_n !== 64'h0) begin errors++; $display("FAIL x0_commit got %h/%h exp 0", rd_b, rd_n); end
    endtask

    task automatic test_bypass();
        we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'h0, 32'h1111};
        tick();
        we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'h0, 32'h1234}; ra = {5'd7, 5'd7};
        #1;
        checks++; if (rd_b !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL bypass_on got %h exp %h", rd_b, {32'h1234, 32'h1234}); end
        checks++; if (rd_n !== {32'h1111, 32'h1111}) begin errors++; $display("FAIL bypass_off_old got %h exp %h", rd_n, {32'h1111, 32'h1111}); end
        tick();
        idle();
        #1;
        checks++; if (rd_n !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL bypass_off_new got %h exp %h", rd_n, {32'h1234, 32'h1234}); end
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h5678, 32'h9ABC}; ra = {5'd0, 5'd7};
        #1;
        checks++; if (rd_b !== {32'h0, 32'h5678}) begin errors++; $display("FAIL bypass_winner got %h exp %h", rd_b, {32'h0, 32'h5678}); end
        checks++; if (rd_n !== {32'h0, 32'h1234}) begin errors++; $display("FAIL bypass_off_hold got %h exp %h", rd_n, {32'h0, 32'h1234}); end
        tick();
        idle();
        #1;
        checks++; if (rd_n !== {32'h0, 32'h5678}) begin errors++; $display("FAIL bypass_off_winner got %h exp %h", rd_n, {32'h0, 32'h5678}); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_addr = 5'd9; ra = {5'd0, 5'd9};
        #1;
        checks++; if (bz_b !== 2'b00 || bz_n !== 2'b00) begin errors++; $display("FAIL sb_before_issue got %b/%b exp 00", bz_b, bz_n); end
        tick();
        idle();
        #1;
        checks++; if (bz_b !== 2'b01 || bz_n !== 2'b01) begin errors++; $display("FAIL sb_issued got %b/%b exp 01", bz_b, bz_n); end
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h99};
        #1;
        checks++; if (bz_b !== 2'b00) begin errors++; $display("FAIL sb_wb_bypass got %b exp 00", bz_b); end
        checks++; if (bz_n !== 2'b01) begin errors++; $display("FAIL sb_wb_nobypass got %b exp 01", bz_n); end
        tick();
        idle();
        #1;
        checks++; if (bz_b !== 2'b00 || bz_n !== 2'b00) begin errors++; $display("FAIL sb_cleared got %b/%b exp 00", bz_b, bz_n); end
        checks++; if (rd_b !== {32'h0, 32'h99}) begin errors++; $display("FAIL sb_wb_data got %h exp %h", rd_b, {32'h0, 32'h99}); end
        iss_valid = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd9; we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'hAB};
        #1;
        checks++; if (bz_b !== 2'b01) begin errors++; $display("FAIL sb_set_clear_bypass got %b exp 01", bz_b); end
        tick();
        idle();
        #1;
        checks++; if (bz_b !== 2'b01 || bz_n !== 2'b01) begin errors++; $display("FAIL sb_set_wins got %b/%b exp 01", bz_b, bz_n); end
        checks++; if (rd_n !== {32'h0, 32'hAB}) begin errors++; $display("FAIL sb_set_wins_data got %h exp %h", rd_n, {32'h0, 32'hAB}); end
        iss_valid = 1'b1; iss_addr = 5'd10; we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h77, 32'h0}; ra = {5'd10, 5'd9};
        tick();
        idle();
        iss_valid = 1'b1; iss_addr = 5'd0; ra = {5'd0, 5'd10};
        tick();
        idle();
        #1;
        checks++; if (bz_b !== 2'b01 || bz_n !== 2'b01) begin errors++; $display("FAIL sb_x0_issue got %b/%b exp 01", bz_b, bz_n); end
        ra = {5'd10, 5'd9};
        #1;
        checks++; if (bz_n !== 2'b10) begin errors++; $display("FAIL sb_split got %b exp 10", bz_n); end
    endtask

    task automatic test_random();
        logic [4:0]  a, wak;
        logic [63:0] exp_b, exp_n;
        logic [1:0]  exp_bzb, exp_bzn;
        logic [31:0] v;
        logic        bz, hit;
        rst_n = 1'b0;
        idle();
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            mregs[r] = 32'h0;
            mbusy[r] = 1'b0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            we = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                wa[k*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                ra[k*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                wd[k*32 +: 32] = $urandom;
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            #1;
            for (int j = 0; j < 2; j++) begin
                a = ra[j*5 +: 5];
                exp_n[j*32 +: 32] = mregs[a];
                exp_bzn[j] = mbusy[a];
                v = mregs[a];
                bz = mbusy[a];
                hit = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    wak = wa[k*5 +: 5];
                    if (we[k] && wak == a) begin
                        v = wd[k*32 +: 32];
                        hit = 1'b1;
                    end
                end
                if (hit && !(iss_valid && iss_addr == a))
                    bz = 1'b0;
                if (a == 5'd0) begin
                    v = 32'h0;
                    bz = 1'b0;
                end
                exp_b[j*32 +: 32] = v;
                exp_bzb[j] = bz;
            end
            checks++; if (rd_b !== exp_b) begin errors++; $display("FAIL rand_rd_byp cyc %0d got %h exp %h", cyc, rd_b, exp_b); end
            checks++; if (bz_b !== exp_bzb) begin errors++; $display("FAIL rand_busy_byp cyc %0d got %b exp %b", cyc, bz_b, exp_bzb); end
            checks++; if (rd_n !== exp_n) begin errors++; $display("FAIL rand_rd_nobyp cyc %0d got %h exp %h", cyc, rd_n, exp_n); end
            checks++; if (bz_n !== exp_bzn) begin errors++; $display("FAIL rand_busy_nobyp cyc %0d got %b exp %b", cyc, bz_n, exp_bzn); end
            tick();
            for (int k = 0; k < 2; k++) begin
                wak = wa[k*5 +: 5];
                if (we[k] && wak != 5'd0) begin
                    mregs[wak] = wd[k*32 +: 32];
                    mbusy[wak] = 1'b0;
                end
            end
            if (iss_valid && iss_addr != 5'd0)
                mbusy[iss_addr] = 1'b1;
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_x0_conflict();
        test_bypass();
        test_scoreboard();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
